// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared GPIO definitions: register indices and pad output-enable polarity.
// Used by gpio_pad_ctrl and gpio_in_filter (optional feature macro: GPIO_DEBOUNCE_EN).
package gpio_pad_ctrl_pkg;

  typedef enum logic [2:0] {
    GPIO_REG_OUT   = 3'd0,
    GPIO_REG_OEN   = 3'd1,
    GPIO_REG_IN    = 3'd2,
    GPIO_REG_IEN   = 3'd3,
    GPIO_REG_IPOL  = 3'd4,
    GPIO_REG_ISTAT = 3'd5
  } gpio_reg_e;

  // Pad OEN is active-low: 1 tristates the driver, so reset leaves every pin an input.
  localparam logic GPIO_OEN_INPUT = 1'b1;

endpackage

// File: rtl/gpio_pad_ctrl_in_filter.sv
// Per-bit pad input path: 2-flop synchroniser, optional debounce, edge detect.
// Debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_c,
  output logic filt,
  output logic rise,
  output logic fall
);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("gpio_in_filter: DB_CYCLES must be >= 2");
  end

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive cycles that s2 disagrees with filt; agreement restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  always_comb begin
    s1_d   = pad_c;
    s2_d   = s1_q;
    prev_d = filt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-mapped GPIO controller: pad drive/OEN registers, synchronised input, edge interrupts.
// Optional input debounce selected with GPIO_DEBOUNCE_EN.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reg_en,
  input  logic         reg_we,
  input  logic [2:0]   reg_addr,
  input  logic [N-1:0] reg_wdata,
  output logic [N-1:0] reg_rdata,
  output logic         reg_rvalid,
  output logic [N-1:0] pad_i,
  output logic [N-1:0] pad_oen,
  input  logic [N-1:0] pad_c,
  output logic         irq
);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("gpio_pad_ctrl: N must be in 1..32");
  end

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] oen_q, oen_d;
  logic [N-1:0] ien_q, ien_d;
  logic [N-1:0] ipol_q, ipol_d;
  logic [N-1:0] istat_q, istat_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;
  logic         irq_q, irq_d;

  logic [N-1:0] filt, rise, fall, evt, w1c;

  for (genvar b = 0; b < int'(N); b++) begin : g_in
    gpio_in_filter #(
      .DB_CYCLES(DB_CYCLES)
    ) u_filt (
      .clk  (clk),
      .reset(reset),
      .pad_c(pad_c[b]),
      .filt (filt[b]),
      .rise (rise[b]),
      .fall (fall[b])
    );
  end

  assign evt = (ipol_q & fall) | (~ipol_q & rise);

  always_comb begin
    out_d    = out_q;
    oen_d    = oen_q;
    ien_d    = ien_q;
    ipol_d   = ipol_q;
    rdata_d  = rdata_q;
    rvalid_d = reg_en & ~reg_we;
    w1c      = '0;

    if (reg_en && reg_we) begin
      case (gpio_reg_e'(reg_addr))
        GPIO_REG_OUT:   out_d  = reg_wdata;
        GPIO_REG_OEN:   oen_d  = reg_wdata;
        GPIO_REG_IEN:   ien_d  = reg_wdata;
        GPIO_REG_IPOL:  ipol_d = reg_wdata;
        GPIO_REG_ISTAT: w1c    = reg_wdata;
        default:        ;
      endcase
    end

    if (reg_en && !reg_we) begin
      case (gpio_reg_e'(reg_addr))
        GPIO_REG_OUT:   rdata_d = out_q;
        GPIO_REG_OEN:   rdata_d = oen_q;
        GPIO_REG_IN:    rdata_d = filt;
        GPIO_REG_IEN:   rdata_d = ien_q;
        GPIO_REG_IPOL:  rdata_d = ipol_q;
        GPIO_REG_ISTAT: rdata_d = istat_q;
        default:        rdata_d = '0;
      endcase
    end

    // Set term OR'd after the clear so a coincident W1C never drops a new event.
    istat_d = (istat_q & ~w1c) | (evt & ien_q);
    irq_d   = |(istat_q & ien_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      oen_q    <= {N{GPIO_OEN_INPUT}};
      ien_q    <= '0;
      ipol_q   <= '0;
      istat_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      oen_q    <= oen_d;
      ien_q    <= ien_d;
      ipol_q   <= ipol_d;
      istat_q  <= istat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign pad_i      = out_q;
  assign pad_oen    = oen_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl with a read-data scoreboard queue.
// Timing expectations stretch by DB_CYCLES when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_pad_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DB = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int XL = DB;
`else
  localparam int XL = 0;
`endif

  logic         clk;
  logic         reset;
  logic         reg_en;
  logic         reg_we;
  logic [2:0]   reg_addr;
  logic [N-1:0] reg_wdata;
  logic [N-1:0] reg_rdata;
  logic         reg_rvalid;
  logic [N-1:0] pad_i;
  logic [N-1:0] pad_oen;
  logic [N-1:0] pad_c;
  logic         irq;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];

  gpio_pad_ctrl #(
    .N(N),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_en    (reg_en),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_rvalid(reg_rvalid),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .pad_c     (pad_c),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cyc();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [N-1:0] e);
    logic [N-1:0] x;
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    exp_q.push_back(e);
    cyc();
    reg_en = 1'b0;
    check({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
    x = exp_q.pop_front();
    check(tag, 32'(reg_rdata), 32'(x));
  endtask

  initial begin
    reset = 1'b1; reg_en = 1'b0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; pad_c = '0;
    cyc(); cyc();
    check("rst_pad_oen", 32'(pad_oen), 32'hFF);
    check("rst_pad_i",   32'(pad_i),   32'h00);
    check("rst_irq",     32'(irq),     32'd0);
    check("rst_rvalid",  32'(reg_rvalid), 32'd0);
    check("rst_rdata",   32'(reg_rdata),  32'd0);
    reset = 1'b0;
    cyc();

    // 1. reset values of every register
    rd("r_out",   3'd0, 8'h00);
    rd("r_oen",   3'd1, 8'hFF);
    rd("r_in",    3'd2, 8'h00);
    rd("r_ien",   3'd3, 8'h00);
    rd("r_ipol",  3'd4, 8'h00);
    rd("r_istat", 3'd5, 8'h00);
    rd("r_6",     3'd6, 8'h00);
    rd("r_7",     3'd7, 8'h00);

    // 2. pad drive
    wr(3'd1, 8'hF0);
    check("pad_oen_wr", 32'(pad_oen), 32'hF0);
    wr(3'd0, 8'h5A);
    check("pad_i_wr", 32'(pad_i), 32'h5A);
    rd("r_out2", 3'd0, 8'h5A);
    cyc();
    check("rvalid_pulse", 32'(reg_rvalid), 32'd0);
    wr(3'd6, 8'hAA);
    wr(3'd2, 8'hFF);
    rd("r_6_wr", 3'd6, 8'h00);
    rd("r_in_wr", 3'd2, 8'h00);

    // 3. rising edge on bit 0
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h00);
    pad_c = 8'h01;
    cyc(); cyc();
    repeat (XL) cyc();
    rd("in_b0", 3'd2, 8'h01);
    check("irq_e3", 32'(irq), 32'd0);
    cyc();
    check("irq_e4", 32'(irq), 32'd1);
    rd("istat_b0", 3'd5, 8'h01);
    wr(3'd5, 8'h01);
    check("irq_w1c_1", 32'(irq), 32'd1);
    cyc();
    check("irq_w1c_2", 32'(irq), 32'd0);

    // 4. falling edge on bit 1 with coincident W1C
    pad_c = 8'h03;
    repeat (4 + XL) cyc();
    wr(3'd4, 8'h02);
    wr(3'd3, 8'h02);
    rd("ipol_noevt", 3'd5, 8'h00);
    pad_c = 8'h01;
    cyc(); cyc();
    repeat (XL) cyc();
    wr(3'd5, 8'h02);
    rd("istat_setwins", 3'd5, 8'h02);
    check("irq_b1", 32'(irq), 32'd1);
    wr(3'd3, 8'h00);
    rd("istat_ien_off", 3'd5, 8'h02);
    check("irq_ien_off", 32'(irq), 32'd0);
    wr(3'd5, 8'h02);
    rd("istat_clr", 3'd5, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
    // 5. debounce: short pulse rejected, long level accepted
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h04);
    pad_c = 8'h05;
    repeat (10) cyc();
    pad_c = 8'h01;
    repeat (25) cyc();
    rd("db_glitch_in", 3'd2, 8'h01);
    rd("db_glitch_istat", 3'd5, 8'h00);
    pad_c = 8'h05;
    repeat (17) cyc();
    rd("db_in_early", 3'd2, 8'h01);
    rd("db_in_late",  3'd2, 8'h05);
`endif

    // 6. reset discards pending interrupts
    pad_c = 8'h00;
    repeat (4 + XL) cyc();
    wr(3'd5, 8'hFF);
    wr(3'd4, 8'h00);
    wr(3'd3, 8'hFF);
    pad_c = 8'hFF;
    repeat (5 + XL) cyc();
    rd("istat_all", 3'd5, 8'hFF);
    check("irq_all", 32'(irq), 32'd1);
    reset = 1'b1;
    cyc();
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_oen", 32'(pad_oen), 32'hFF);
    check("mid_rst_pad_i", 32'(pad_i), 32'h00);
    reset = 1'b0;
    rd("mid_rst_istat", 3'd5, 8'h00);
    rd("mid_rst_ien", 3'd3, 8'h00);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
